// File: rtl/spi_slave_ctrl_pkg.sv
// Shared definitions for the SPI slave front end: FSM states, command
// encodings carried in rx_data[9:8] and the default word widths.
package spi_slave_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int RX_W   = DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: one command-select bit, then a 10-bit word
// {cmd, payload} shifted in MSB first and handed to the RAM side as a
// single rx_valid pulse. Read data returned by the RAM is shifted out on
// MISO, MSB first, once the read-data word of the frame has completed.
module spi_slave_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SS_n,
    input  logic                MOSI,
    input  logic                tx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    output logic                MISO,
    output logic                rx_valid,
    output logic [DATA_W+1:0]   rx_data
);

    localparam int WORD_W   = DATA_W + 2;
    localparam int RX_CNT_W = $clog2(WORD_W + 1);
    localparam int TX_CNT_W = $clog2(DATA_W + 1);

    localparam logic [RX_CNT_W-1:0] RX_FULL = RX_CNT_W'(WORD_W);
    localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(WORD_W - 1);
    localparam logic [TX_CNT_W-1:0] TX_LEN  = TX_CNT_W'(DATA_W);

    state_t                 state_reg;
    logic [RX_CNT_W-1:0]    rx_cnt_reg;
    logic [WORD_W-1:0]      rx_data_reg;
    logic                   rx_valid_reg;
    logic                   rd_addr_seen_reg;
    logic                   tx_wait_reg;
    logic [TX_CNT_W-1:0]    tx_cnt_reg;
    logic [DATA_W-1:0]      tx_shift_reg;
    logic                   miso_reg;

    // Frame FSM with the receive shifter and the read-data serialiser.
    // The rd_addr_seen flag survives SS_n going high so a read-address
    // frame and the following read-data frame pair up across frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            rx_cnt_reg       <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rd_addr_seen_reg <= 1'b0;
            tx_wait_reg      <= 1'b0;
            tx_cnt_reg       <= '0;
            tx_shift_reg     <= '0;
            miso_reg         <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            miso_reg     <= 1'b0;
            if (SS_n) begin
                // Frame ended: discard any partial word and pending read.
                state_reg   <= IDLE;
                rx_cnt_reg  <= '0;
                tx_wait_reg <= 1'b0;
                tx_cnt_reg  <= '0;
            end else begin
                // Serialiser runs independently of the receive side.
                if (tx_cnt_reg != '0) begin
                    miso_reg     <= tx_shift_reg[DATA_W-1];
                    tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                    tx_cnt_reg   <= tx_cnt_reg - 1'b1;
                end
                case (state_reg)
                    IDLE: begin
                        state_reg <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        if (!MOSI)
                            state_reg <= WRITE;
                        else if (rd_addr_seen_reg)
                            state_reg <= READ_DATA;
                        else
                            state_reg <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        // Bits past the tenth are ignored until the frame ends.
                        if (rx_cnt_reg < RX_FULL) begin
                            rx_data_reg <= {rx_data_reg[WORD_W-2:0], MOSI};
                            rx_cnt_reg  <= rx_cnt_reg + 1'b1;
                            if (rx_cnt_reg == RX_LAST) begin
                                rx_valid_reg <= 1'b1;
                                if (state_reg == READ_ADD)
                                    rd_addr_seen_reg <= 1'b1;
                                if (state_reg == READ_DATA) begin
                                    rd_addr_seen_reg <= 1'b0;
                                    tx_wait_reg      <= 1'b1;
                                end
                            end
                        end
                        // Only one read word per frame is accepted.
                        if (state_reg == READ_DATA && tx_wait_reg && tx_valid) begin
                            tx_shift_reg <= tx_data;
                            tx_cnt_reg   <= TX_LEN;
                            tx_wait_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign MISO     = miso_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl. The reference model tracks only the
// "read address already seen" bit and, per frame, the word that must
// appear once on rx_data and the byte (if any) that must appear on MISO.
module tb_spi_slave_ctrl;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          SS_n;
    logic          MOSI;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          MISO;
    logic          rx_valid;
    logic [DW+1:0] rx_data;

    int tests  = 0;
    int errors = 0;

    // Model state and rx monitor results.
    bit            m_seen = 1'b0;
    int            pulse_total = 0;
    logic [DW+1:0] last_rx = '0;

    spi_slave_ctrl #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .MISO     (MISO),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every rx_valid pulse shortly after the edge that raised it.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            pulse_total = pulse_total + 1;
            last_rx     = rx_data;
        end
    end

    // One frame: select bit, nbits of word (extra bits random), optional
    // delay then a tx_valid pulse, MISO observed for 10 clocks, then close.
    task automatic do_frame(input bit chk, input logic [9:0] w, input int nbits,
                            input int dly, input logic [DW-1:0] txv, input string name);
        int            p0;
        bit            is_rd_data;
        logic [9:0]    miso_obs;
        logic [9:0]    miso_exp;
        p0 = pulse_total;
        is_rd_data = chk && m_seen;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'($urandom);
        @(negedge clk); MOSI = chk;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI = (i < 10) ? w[9-i] : 1'($urandom);
        end
        @(negedge clk); MOSI = 1'b0;
        repeat (dly) @(negedge clk);
        tx_valid = 1'b1; tx_data = txv;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            tx_valid = 1'b0;
            miso_obs[9-k] = MISO;
        end
        // Model: a read-data frame returns the byte MSB first starting the
        // second clock after tx_valid is taken; otherwise MISO stays low.
        miso_exp = is_rd_data ? {1'b0, txv, 1'b0} : 10'd0;
        if (chk) m_seen = !m_seen;
        @(negedge clk); SS_n = 1'b1;
        @(negedge clk);

        tests++;
        if ((pulse_total - p0) !== 1) begin
            errors++;
            $display("FAIL %s pulses: got %0d expected 1", name, pulse_total - p0);
        end
        tests++;
        if (last_rx !== w) begin
            errors++;
            $display("FAIL %s rx_data: got %h expected %h", name, last_rx, w);
        end
        tests++;
        if (miso_obs !== miso_exp) begin
            errors++;
            $display("FAIL %s miso: got %b expected %b", name, miso_obs, miso_exp);
        end
        $display("[TB] %s chk=%0d word=%h rd_data=%0d tx=%h miso=%b", name, chk, w,
                 is_rd_data, txv, miso_obs);
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b0; tx_data = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (rx_valid !== 1'b0 || rx_data !== 10'd0 || MISO !== 1'b0) begin
            errors++;
            $display("FAIL reset: got rx_valid=%b rx_data=%h MISO=%b expected 0/000/0",
                     rx_valid, rx_data, MISO);
        end
        rst = 1'b0; SS_n = 1'b1;
        @(negedge clk);
        m_seen = 1'b0;
        $display("[TB] reset done");
    endtask

    task automatic test_write_addr();
        do_frame(1'b0, 10'h005, 10, 0, 8'h3C, "write_addr");
    endtask

    task automatic test_read_seq();
        do_frame(1'b1, 10'h233, 10, 0, 8'h77, "read_addr");
        do_frame(1'b1, 10'h300, 10, 0, 8'hA5, "read_data");
    endtask

    task automatic test_abort();
        int p0;
        p0 = pulse_total;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b1;
        @(negedge clk); MOSI = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); MOSI = 1'b1;
        end
        @(negedge clk); SS_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (pulse_total != p0) begin
            errors++;
            $display("FAIL abort pulses: got %0d expected 0", pulse_total - p0);
        end
        $display("[TB] abort after 5 bits pulses=%0d", pulse_total - p0);
        do_frame(1'b0, 10'h1FF, 10, 0, 8'h00, "after_abort");
    endtask

    task automatic test_rd_flag();
        do_frame(1'b1, 10'h2AA, 10, 1, 8'h5A, "flag_add");
        do_frame(1'b1, 10'h3C3, 12, 2, 8'hC3, "flag_data");
        do_frame(1'b1, 10'h211, 10, 0, 8'hFF, "flag_cleared");
        // Reset must clear the flag left set by the previous frame.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_seen = 1'b0;
        do_frame(1'b1, 10'h201, 10, 0, 8'h81, "flag_after_rst");
        do_frame(1'b1, 10'h3FE, 10, 3, 8'h81, "flag_rd_after_rst");
    endtask

    task automatic test_sweep();
        int p0;
        int bad;
        logic [9:0] w;
        p0 = pulse_total;
        bad = 0;
        for (int p = 0; p < 100; p++) begin
            w = {2'b00, 8'(p)};
            @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
            @(negedge clk); MOSI = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk); MOSI = w[9-i];
            end
            @(negedge clk); SS_n = 1'b1;
            if (last_rx !== w || pulse_total != p0 + p + 1) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sweep: got %0d bad frames expected 0", bad);
        end
        tests++;
        if (pulse_total - p0 != 100) begin
            errors++;
            $display("FAIL sweep pulses: got %0d expected 100", pulse_total - p0);
        end
        $display("[TB] sweep 0..99 pulses=%0d bad=%0d", pulse_total - p0, bad);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            do_frame(1'($urandom), 10'($urandom), 10 + int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 8'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_read_seq();
        test_abort();
        test_rd_flag();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
